// File: rtl/recip_pkg.sv
// Shared types, default widths and the reference reciprocal function for the
// reciprocal lookup unit.
package recip_pkg;

  typedef enum logic [1:0] {
    DIV = 2'd0,
    WR  = 2'd1,
    RUN = 2'd2
  } recip_state_e;

  localparam int DEF_ADDR_W   = 4;
  localparam int DEF_FRAC_W   = 8;
  localparam int DEF_OUT_W    = 16;
  localparam int DEF_MAX_ADDR = 11;
  // Dividend holds 2^FRAC_W; remainder/divisor must hold idx+1 up to 2^ADDR_W.
  localparam int DEF_DVD_W    = DEF_FRAC_W + 1;
  localparam int DEF_DVS_W    = DEF_ADDR_W + 1;

  function automatic int unsigned recip_ref(input int unsigned idx,
                                            input int unsigned frac_w);
    int unsigned num;
    int unsigned q;
    num = 32'd1 << frac_w;
    q   = num / (idx + 1);
    if (q > num - 1) q = num - 1;
    return q;
  endfunction

  function automatic int unsigned build_cycles(input int unsigned max_addr,
                                               input int unsigned frac_w);
    return (max_addr + 1) * (frac_w + 2);
  endfunction

endpackage

// File: rtl/recip_lut_seq_div.sv
// Iterative restoring divider: one quotient bit per cycle, MSB first.
// The first bit is produced on the start edge, so a division takes DVD_W cycles.
module recip_div_seq #(
  parameter int DVD_W = 9,
  parameter int DVS_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [DVD_W-1:0] dividend_i,
  input  logic [DVS_W-1:0] divisor_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [DVD_W-1:0] quotient_o
);

  localparam int CNT_W = (DVD_W > 2) ? $clog2(DVD_W) : 1;

  logic [DVD_W-1:0] dvd_q, dvd_d;
  logic [DVD_W-1:0] quo_q, quo_d;
  logic [DVS_W-1:0] rem_q, rem_d;
  logic [DVS_W-1:0] dvs_q, dvs_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;

  logic             load;
  logic [DVS_W-1:0] rem_in;
  logic [DVS_W-1:0] dvs_in;
  logic [DVD_W-1:0] dvd_in;
  logic [DVD_W-1:0] quo_in;
  logic [DVS_W:0]   trial;
  logic             q_bit;

  assign load = start_i && !busy_q;

  always_comb begin
    rem_in = load ? '0 : rem_q;
    dvs_in = load ? divisor_i : dvs_q;
    dvd_in = load ? dividend_i : dvd_q;
    quo_in = load ? '0 : quo_q;
    trial  = {rem_in, dvd_in[DVD_W-1]};
    q_bit  = (trial >= {1'b0, dvs_in});

    dvd_d  = dvd_q;
    quo_d  = quo_q;
    rem_d  = rem_q;
    dvs_d  = dvs_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;

    if (load || busy_q) begin
      dvd_d = dvd_in << 1;
      quo_d = {quo_in[DVD_W-2:0], q_bit};
      dvs_d = dvs_in;
      // The true difference is below the divisor, so the low bits are exact.
      rem_d = q_bit ? (trial[DVS_W-1:0] - dvs_in) : trial[DVS_W-1:0];
    end

    if (load) begin
      cnt_d  = CNT_W'(DVD_W - 1);
      busy_d = 1'b1;
    end else if (busy_q) begin
      cnt_d  = cnt_q - CNT_W'(1);
      busy_d = (cnt_q != CNT_W'(1));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dvd_q  <= '0;
      quo_q  <= '0;
      rem_q  <= '0;
      dvs_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      dvd_q  <= dvd_d;
      quo_q  <= quo_d;
      rem_q  <= rem_d;
      dvs_q  <= dvs_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

  assign busy_o     = busy_q;
  assign done_o     = busy_q && (cnt_q == CNT_W'(1));
  assign quotient_o = quo_q;

endmodule

// File: rtl/recip_lut_seq.sv
// Reciprocal lookup unit: builds floor(2^FRAC_W/(i+1)) into a register file
// after reset or rebuild, then serves one registered lookup per cycle.
module recip_lut_seq
  import recip_pkg::*;
#(
  parameter int ADDR_W   = 4,
  parameter int FRAC_W   = 8,
  parameter int OUT_W    = 16,
  parameter int MAX_ADDR = 11
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rebuild,
  input  logic              in_valid,
  input  logic [ADDR_W-1:0] in_addr,
  output logic              in_ready,
  output logic              out_valid,
  output logic [OUT_W-1:0]  out_data,
  output logic              out_err,
  output logic              init_done,
  output logic [1:0]        dbg_state_o
);

  localparam int DVD_W = FRAC_W + 1;
  localparam int DVS_W = ADDR_W + 1;
  localparam logic [ADDR_W-1:0] MAX_IDX = ADDR_W'(MAX_ADDR);
  localparam logic [ADDR_W:0]   MAX_X   = (ADDR_W + 1)'(MAX_ADDR);

  recip_state_e      state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic              div_start;
  logic              div_busy;
  logic              div_done;
  logic [DVD_W-1:0]  div_quo;
  logic              tbl_we;
  logic [FRAC_W-1:0] tbl_wdata;
  logic [FRAC_W-1:0] table_q [MAX_ADDR+1];

  logic              accept;
  logic              addr_err;
  logic [OUT_W-1:0]  rd_data;
  logic              out_valid_q;
  logic [OUT_W-1:0]  out_data_q;
  logic              out_err_q;

  recip_div_seq #(
    .DVD_W(DVD_W),
    .DVS_W(DVS_W)
  ) u_div (
    .clk       (clk),
    .rst_n     (rst_n),
    .start_i   (div_start),
    .dividend_i({1'b1, {FRAC_W{1'b0}}}),
    .divisor_i (DVS_W'(idx_q) + DVS_W'(1)),
    .busy_o    (div_busy),
    .done_o    (div_done),
    .quotient_o(div_quo)
  );

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    div_start = 1'b0;
    tbl_we    = 1'b0;
    unique case (state_q)
      DIV: begin
        div_start = !div_busy;
        if (div_done) state_d = WR;
      end
      WR: begin
        tbl_we = 1'b1;
        if (idx_q == MAX_IDX) begin
          state_d = RUN;
        end else begin
          idx_d   = idx_q + ADDR_W'(1);
          state_d = DIV;
        end
      end
      RUN: begin
        if (rebuild) begin
          state_d = DIV;
          idx_d   = '0;
        end
      end
      default: state_d = DIV;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= DIV;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Only entry 0 (divide by one) can exceed the fraction range.
  assign tbl_wdata = div_quo[FRAC_W] ? '1 : div_quo[FRAC_W-1:0];

  always_ff @(posedge clk) begin
    if (tbl_we) table_q[idx_q] <= tbl_wdata;
  end

  // Handshake: a request is taken on any edge where in_valid && in_ready;
  // out_valid pulses for exactly one cycle after it, with no backpressure.
  // out_data/out_err stay put until the next accepted request.
  assign accept   = in_valid && in_ready;
  assign addr_err = ({1'b0, in_addr} > MAX_X);
  assign rd_data  = addr_err ? '0 : OUT_W'(table_q[in_addr]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_err_q   <= 1'b0;
    end else begin
      out_valid_q <= accept;
      if (accept) begin
        out_data_q <= rd_data;
        out_err_q  <= addr_err;
      end
    end
  end

  assign in_ready    = (state_q == RUN);
  assign init_done   = in_ready;
  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign out_err     = out_err_q;
  assign dbg_state_o = state_q;

endmodule
